// File: rtl/switch_debounce.sv
// Switch input conditioner: two-flop synchronizer, per-channel stability
// counter, and registered level / rise / fall / toggle / changed outputs.
module switch_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] sw_state,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] sw_toggle,
    output logic             changed
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            r_s1;
    logic [WIDTH-1:0]            r_s2;
    logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]            r_state;
    logic [WIDTH-1:0]            r_rise;
    logic [WIDTH-1:0]            r_fall;
    logic [WIDTH-1:0]            r_toggle;
    logic                        r_changed;

    logic [WIDTH-1:0]            w_differ;
    logic [WIDTH-1:0]            w_accept;
    logic [WIDTH-1:0]            w_rise;
    logic [WIDTH-1:0]            w_fall;

    // Raw pins are asynchronous; only r_s2 is safe to use downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= switches;
            r_s2 <= r_s1;
        end
    end

    always_comb begin
        w_differ = r_s2 ^ r_state;
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = w_differ[i] && (r_cnt[i] == LP_CNT_LAST);
        end
    end

    assign w_rise = w_accept & r_s2;
    assign w_fall = w_accept & ~r_s2;

    // Agreement or acceptance clears the count, so it can never exceed LP_CNT_LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_differ[i] || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= '0;
            r_rise    <= '0;
            r_fall    <= '0;
            r_toggle  <= '0;
            r_changed <= 1'b0;
        end else begin
            r_state   <= r_state ^ w_accept;
            r_rise    <= w_rise;
            r_fall    <= w_fall;
            r_toggle  <= r_toggle ^ w_rise;
            r_changed <= |w_accept;
        end
    end

    assign sw_state  = r_state;
    assign sw_rise   = r_rise;
    assign sw_fall   = r_fall;
    assign sw_toggle = r_toggle;
    assign changed   = r_changed;

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce: directed scenarios plus a random
// run compared against a sample-history reference model.
module tb_switch_debounce;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk      = 1'b0;
    logic         clk_en   = 1'b0;
    logic         rst_n    = 1'b1;
    logic [W-1:0] switches = '0;
    logic [W-1:0] sw_state;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic [W-1:0] sw_toggle;
    logic         changed;

    int pass_cnt  = 0;
    int total_cnt = 0;

    switch_debounce #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .switches  (switches),
        .sw_state  (sw_state),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_toggle (sw_toggle),
        .changed   (changed)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Reference model: a level is accepted once the last D synchronized
    // samples all disagree with the current debounced level.
    logic [W-1:0] m_s1 = '0;
    logic [W-1:0] m_s2 = '0;
    bit           hist [W][$];
    logic [W-1:0] e_state = '0;
    logic [W-1:0] e_rise  = '0;
    logic [W-1:0] e_fall  = '0;
    logic [W-1:0] e_tog   = '0;
    logic         e_chg   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0;
            e_state = '0; e_rise = '0; e_fall = '0; e_tog = '0; e_chg = 1'b0;
            for (int i = 0; i < W; i++) hist[i].delete();
        end else begin
            e_rise = '0;
            e_fall = '0;
            for (int i = 0; i < W; i++) begin
                bit acc;
                hist[i].push_back(m_s2[i]);
                if (hist[i].size() > D) void'(hist[i].pop_front());
                acc = (hist[i].size() == D);
                foreach (hist[i][k]) if (hist[i][k] == e_state[i]) acc = 1'b0;
                if (acc) begin
                    if (m_s2[i]) begin
                        e_rise[i] = 1'b1;
                        e_tog[i]  = ~e_tog[i];
                    end else begin
                        e_fall[i] = 1'b1;
                    end
                    e_state[i] = m_s2[i];
                end
            end
            e_chg = |(e_rise | e_fall);
            m_s2 = m_s1;
            m_s1 = switches;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        switches = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [4*W:0] obs;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
        total_cnt++;
        if (obs !== '0) $display("FAIL reset_immediate: got %h expected 0", obs);
        else pass_cnt++;
        #20;
        obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
        total_cnt++;
        if (obs !== '0) $display("FAIL reset_hold_noclk: got %h expected 0", obs);
        else pass_cnt++;
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
            total_cnt++;
            if (obs !== '0) $display("FAIL reset_idle e=%0d: got %h expected 0", e, obs);
            else pass_cnt++;
        end
    endtask

    task automatic test_clean_press();
        logic [4*W:0] obs, exp;
        do_reset();
        switches = 4'b0001;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
            exp = {(e >= 5) ? 4'b0001 : 4'b0000, (e == 5) ? 4'b0001 : 4'b0000,
                   4'b0000, (e >= 5) ? 4'b0001 : 4'b0000, (e == 5)};
            total_cnt++;
            if (obs !== exp) $display("FAIL clean_press e=%0d: got %h expected %h", e, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_bounce();
        logic [4*W:0] obs, exp;
        logic [4:0]   pat;
        do_reset();
        pat = 5'b10110;
        for (int k = 4; k >= 0; k--) begin
            switches[1] = pat[k];
            @(posedge clk); #1;
            obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
            total_cnt++;
            if (obs !== '0) $display("FAIL bounce_quiet k=%0d: got %h expected 0", k, obs);
            else pass_cnt++;
        end
        switches[1] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
            exp = {(e >= 5) ? 4'b0010 : 4'b0000, (e == 5) ? 4'b0010 : 4'b0000,
                   4'b0000, (e >= 5) ? 4'b0010 : 4'b0000, (e == 5)};
            total_cnt++;
            if (obs !== exp) $display("FAIL bounce_settle e=%0d: got %h expected %h", e, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_glitch();
        logic [4*W:0] obs;
        do_reset();
        for (int e = 0; e < 15; e++) begin
            switches[2] = (e < 3);
            @(posedge clk); #1;
            obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
            total_cnt++;
            if (obs !== '0) $display("FAIL glitch e=%0d: got %h expected 0", e, obs);
            else pass_cnt++;
        end
    endtask

    task automatic test_multi_release();
        logic [4*W:0] obs, exp;
        do_reset();
        switches = 4'b1010;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
            exp = {(e >= 5) ? 4'b1010 : 4'b0000, (e == 5) ? 4'b1010 : 4'b0000,
                   4'b0000, (e >= 5) ? 4'b1010 : 4'b0000, (e == 5)};
            total_cnt++;
            if (obs !== exp) $display("FAIL multi_press e=%0d: got %h expected %h", e, obs, exp);
            else pass_cnt++;
        end
        switches = 4'b0000;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk); #1;
            obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
            exp = {(e < 5) ? 4'b1010 : 4'b0000, 4'b0000,
                   (e == 5) ? 4'b1010 : 4'b0000, 4'b1010, (e == 5)};
            total_cnt++;
            if (obs !== exp) $display("FAIL multi_release e=%0d: got %h expected %h", e, obs, exp);
            else pass_cnt++;
        end
        switches = 4'b1010;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
            exp = {(e >= 5) ? 4'b1010 : 4'b0000, (e == 5) ? 4'b1010 : 4'b0000,
                   4'b0000, (e >= 5) ? 4'b0000 : 4'b1010, (e == 5)};
            total_cnt++;
            if (obs !== exp) $display("FAIL multi_repress e=%0d: got %h expected %h", e, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midcount();
        logic [4*W:0] obs, exp;
        do_reset();
        switches = 4'b1000;
        for (int e = 0; e < 3; e++) begin
            @(posedge clk); #1;
            obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
            total_cnt++;
            if (obs !== '0) $display("FAIL midcount_pre e=%0d: got %h expected 0", e, obs);
            else pass_cnt++;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
            exp = {(e >= 6) ? 4'b1000 : 4'b0000, (e == 6) ? 4'b1000 : 4'b0000,
                   4'b0000, (e >= 6) ? 4'b1000 : 4'b0000, (e == 6)};
            total_cnt++;
            if (obs !== exp) $display("FAIL midcount_post e=%0d: got %h expected %h", e, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_clear();
        logic [4*W:0] obs;
        do_reset();
        switches = 4'b1111;
        repeat (8) @(posedge clk);
        #1;
        total_cnt++;
        if ({sw_state, sw_toggle} !== 8'hff)
            $display("FAIL async_setup: got %h expected ff", {sw_state, sw_toggle});
        else pass_cnt++;
        clk_en = 1'b0;
        #12 rst_n = 1'b0;
        #1;
        obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
        total_cnt++;
        if (obs !== '0) $display("FAIL async_clear: got %h expected 0", obs);
        else pass_cnt++;
        clk_en = 1'b1;
        switches = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [4*W:0] obs, exp;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 5) == 0) switches[i] = ~switches[i];
            @(posedge clk); #1;
            obs = {sw_state, sw_rise, sw_fall, sw_toggle, changed};
            exp = {e_state, e_rise, e_fall, e_tog, e_chg};
            total_cnt++;
            if (obs !== exp) $display("FAIL random n=%0d: got %h expected %h", n, obs, exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_multi_release();
        test_reset_midcount();
        test_async_clear();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
